ctrlpid_pwm_out: RTL and testbench

- Downstream consumer of the multi-channel PID core.
- Samples each channel's signed motor-power word (m_k, address a) when the core raises ce.
- Converts each word to sign/magnitude and drives one H-bridge per channel as complementary-direction PWM: pwm_a is forward, pwm_b is reverse.
- Duty updates only at period boundaries; a dead-time gap is inserted on every direction reversal.

---
 rtl/ctrlpid_pkg.sv | 25 ++
 rtl/ctrlpid_pwm_chan.sv | 95 +++++++++
 rtl/ctrlpid_pwm_out.sv | 81 ++++++++
 tb/tb_ctrlpid_pwm_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrlpid_pkg.sv
// Shared definitions for the PID-driven PWM output stage: channel FSM
// encoding and width helpers derived from the m_k word width.
package ctrlpid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } chan_state_t;

    localparam int AW_DEF  = 1;
    localparam int OW_DEF  = 12;
    localparam int DTC_DEF = 16;

    // Magnitude/counter width: the signed word minus its sign bit.
    function automatic int mag_w(input int ow);
        return ow - 1;
    endfunction

    function automatic int max_mag(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

endpackage

// File: rtl/ctrlpid_pwm_chan.sv
// One H-bridge channel: direction FSM with dead-time insertion, duty compare
// against the shared period counter, and registered leg outputs.
module ctrlpid_pwm_chan
    import ctrlpid_pkg::*;
#(
    parameter  int ow  = OW_DEF,
    parameter  int dtc = DTC_DEF,
    localparam int mw  = mag_w(ow)
) (
    input  logic          clk_pid,
    input  logic          reset_n,
    input  logic          bnd,
    input  logic [mw-1:0] cnt,
    input  logic          enable,
    input  logic          shadow_sign,
    input  logic [mw-1:0] shadow_mag,
    output logic          pwm_a,
    output logic          pwm_b,
    output logic          upd,
    output chan_state_t   state
);

    localparam logic [mw-1:0] DEAD_LOAD = mw'(dtc);

    logic [mw-1:0] act_mag;
    logic [mw-1:0] dead_cnt;
    logic          tgt_rev;
    logic [mw-1:0] next_mag;

    // Magnitude that will be active after this edge, used to decide whether
    // a finishing dead time lands in IDLE.
    assign next_mag = bnd ? shadow_mag : act_mag;

    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            act_mag  <= '0;
            dead_cnt <= '0;
            tgt_rev  <= 1'b0;
            pwm_a    <= 1'b0;
            pwm_b    <= 1'b0;
            upd      <= 1'b0;
        end else if (!enable) begin
            state    <= ST_IDLE;
            act_mag  <= '0;
            dead_cnt <= '0;
            pwm_a    <= 1'b0;
            pwm_b    <= 1'b0;
            upd      <= 1'b0;
        end else begin
            // Legs derive from a single state value, so they can never overlap.
            pwm_a <= (state == ST_FWD) && (cnt < act_mag);
            pwm_b <= (state == ST_REV) && (cnt < act_mag);
            upd   <= bnd;
            case (state)
                ST_IDLE: begin
                    if (bnd) begin
                        act_mag <= shadow_mag;
                        if (shadow_mag != '0)
                            state <= shadow_sign ? ST_REV : ST_FWD;
                    end
                end
                ST_FWD, ST_REV: begin
                    if (bnd) begin
                        act_mag <= shadow_mag;
                        if (shadow_mag == '0) begin
                            state <= ST_IDLE;
                        end else if (shadow_sign != (state == ST_REV)) begin
                            state    <= ST_DEAD;
                            tgt_rev  <= shadow_sign;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (bnd)
                        act_mag <= shadow_mag;
                    if (bnd && (shadow_mag != '0) && (shadow_sign != tgt_rev)) begin
                        tgt_rev  <= shadow_sign;
                        dead_cnt <= DEAD_LOAD;
                    end else if (dead_cnt == mw'(1)) begin
                        if (next_mag == '0)
                            state <= ST_IDLE;
                        else
                            state <= tgt_rev ? ST_REV : ST_FWD;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ctrlpid_pwm_out.sv
// PID-to-H-bridge PWM output stage: captures each channel's signed power word
// on the rising edge of ce and drives one ctrlpid_pwm_chan per channel.
module ctrlpid_pwm_out
    import ctrlpid_pkg::*;
#(
    parameter  int aw  = AW_DEF,
    parameter  int ow  = OW_DEF,
    parameter  int dtc = DTC_DEF,
    localparam int an  = 1 << aw,
    localparam int mw  = mag_w(ow)
) (
    input  logic                 clk_pid,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [aw-1:0]        a,
    input  logic [ow-1:0]        m_k,
    input  logic [an-1:0]        enable,
    output logic [an-1:0]        pwm_a,
    output logic [an-1:0]        pwm_b,
    output logic [an-1:0]        upd,
    output logic [an-1:0][1:0]   chan_state
);

    logic          ce_d;
    logic [mw-1:0] cnt;
    logic          bnd;
    logic [ow-1:0] mk_neg;
    logic [mw-1:0] mk_mag;
    logic          shadow_sign [an];
    logic [mw-1:0] shadow_mag  [an];
    chan_state_t   st          [an];

    assign bnd = (cnt == '1);

    // Most negative word has no positive twin; clamp it to full scale.
    always_comb begin
        mk_neg = {ow{1'b0}} - m_k;
        mk_mag = m_k[mw-1:0];
        if (m_k[ow-1])
            mk_mag = mk_neg[ow-1] ? '1 : mk_neg[mw-1:0];
    end

    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            ce_d <= 1'b0;
            cnt  <= '0;
            for (int i = 0; i < an; i++) begin
                shadow_sign[i] <= 1'b0;
                shadow_mag[i]  <= '0;
            end
        end else begin
            ce_d <= ce;
            cnt  <= cnt + 1'b1;
            if (ce && !ce_d) begin
                shadow_sign[a] <= m_k[ow-1];
                shadow_mag[a]  <= mk_mag;
            end
        end
    end

    for (genvar ch = 0; ch < an; ch++) begin : g_chan
        ctrlpid_pwm_chan #(
            .ow  (ow),
            .dtc (dtc)
        ) u_chan (
            .clk_pid     (clk_pid),
            .reset_n     (reset_n),
            .bnd         (bnd),
            .cnt         (cnt),
            .enable      (enable[ch]),
            .shadow_sign (shadow_sign[ch]),
            .shadow_mag  (shadow_mag[ch]),
            .pwm_a       (pwm_a[ch]),
            .pwm_b       (pwm_b[ch]),
            .upd         (upd[ch]),
            .state       (st[ch])
        );
        assign chan_state[ch] = st[ch];
    end

endmodule

// File: tb/tb_ctrlpid_pwm_out.sv
// Bench for ctrlpid_pwm_out: table of per-channel duty vectors measured over a
// full period, plus hand-written reversal, ce-hold, enable and reset sequences.
module tb_ctrlpid_pwm_out;
    import ctrlpid_pkg::*;

    localparam int PER = 2048;

    logic            clk_pid = 1'b0;
    logic            reset_n = 1'b0;
    logic            ce      = 1'b0;
    logic [0:0]      a       = '0;
    logic [11:0]     m_k     = '0;
    logic [1:0]      enable  = '0;
    logic [1:0]      pwm_a;
    logic [1:0]      pwm_b;
    logic [1:0]      upd;
    logic [1:0][1:0] chan_state;

    int checks = 0;
    int errors = 0;

    logic [10:0] mcnt;
    int ha [2];
    int hb [2];
    int hu [2];
    int ov;
    int fb0;
    int s15;
    int s16;

    typedef struct {
        int ch;
        int mk;
        int ea;
        int eb;
    } vec_t;

    vec_t vecs [6];
    int   ea [2];
    int   eb [2];

    ctrlpid_pwm_out dut (
        .clk_pid    (clk_pid),
        .reset_n    (reset_n),
        .ce         (ce),
        .a          (a),
        .m_k        (m_k),
        .enable     (enable),
        .pwm_a      (pwm_a),
        .pwm_b      (pwm_b),
        .upd        (upd),
        .chan_state (chan_state)
    );

    always #5 clk_pid = ~clk_pid;

    // Reference period counter: position within the PWM period.
    always @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) mcnt <= '0;
        else          mcnt <= mcnt + 11'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        @(negedge clk_pid);
        while (int'(mcnt) != target && n < 2100) begin
            @(negedge clk_pid);
            n++;
        end
        if (int'(mcnt) != target) check("wait_cnt_timeout", int'(mcnt), target);
    endtask

    task automatic capture(input int ch, input int mk);
        wait_cnt(1000);
        a   = 1'(ch);
        m_k = 12'(mk);
        ce  = 1'b1;
        @(negedge clk_pid);
        ce  = 1'b0;
    endtask

    // Called at the negedge where mcnt==0; samples one full period.
    task automatic measure();
        for (int c = 0; c < 2; c++) begin
            ha[c] = 0;
            hb[c] = 0;
            hu[c] = 0;
        end
        ov  = 0;
        fb0 = -1;
        s15 = -1;
        s16 = -1;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk_pid);
            for (int c = 0; c < 2; c++) begin
                ha[c] += int'(pwm_a[c]);
                hb[c] += int'(pwm_b[c]);
                hu[c] += int'(upd[c]);
                if (pwm_a[c] && pwm_b[c]) ov++;
            end
            if (pwm_b[0] && fb0 < 0) fb0 = i;
            if (i == 15) s15 = int'(chan_state[0]);
            if (i == 16) s16 = int'(chan_state[0]);
        end
    endtask

    initial begin
        vecs[0] = '{ch: 0, mk:   500, ea:  500, eb:    0};
        vecs[1] = '{ch: 1, mk: -2048, ea:    0, eb: 2047};
        vecs[2] = '{ch: 0, mk:  -300, ea:    0, eb:  300};
        vecs[3] = '{ch: 1, mk:     1, ea:    1, eb:    0};
        vecs[4] = '{ch: 0, mk:     0, ea:    0, eb:    0};
        vecs[5] = '{ch: 1, mk:  2047, ea: 2047, eb:    0};
        ea[0] = 0; ea[1] = 0; eb[0] = 0; eb[1] = 0;

        repeat (3) @(negedge clk_pid);
        check("reset_pwm_a", int'(pwm_a), 0);
        check("reset_pwm_b", int'(pwm_b), 0);
        check("reset_upd", int'(upd), 0);
        check("reset_state", int'(chan_state), 0);
        reset_n = 1'b1;
        enable  = 2'b11;

        for (int v = 0; v < 6; v++) begin
            capture(vecs[v].ch, vecs[v].mk);
            ea[vecs[v].ch] = vecs[v].ea;
            eb[vecs[v].ch] = vecs[v].eb;
            wait_cnt(0);
            wait_cnt(0);
            measure();
            for (int c = 0; c < 2; c++) begin
                check($sformatf("vec%0d_ch%0d_a_high", v, c), ha[c], ea[c]);
                check($sformatf("vec%0d_ch%0d_b_high", v, c), hb[c], eb[c]);
                check($sformatf("vec%0d_ch%0d_upd", v, c), hu[c], 1);
            end
            check($sformatf("vec%0d_overlap", v), ov, 0);
        end

        // Forward to reverse: dead time then shortened reverse pulse.
        capture(0, 500);
        wait_cnt(0);
        check("rev_pre_state_fwd", int'(chan_state[0]), int'(ST_FWD));
        capture(0, -300);
        wait_cnt(0);
        check("rev_state_dead", int'(chan_state[0]), int'(ST_DEAD));
        measure();
        check("rev_dead_last", s15, int'(ST_DEAD));
        check("rev_dead_exit", s16, int'(ST_REV));
        check("rev_first_b", fb0, 17);
        check("rev_short_b", hb[0], 284);
        check("rev_short_a", ha[0], 0);
        check("rev_overlap", ov, 0);
        wait_cnt(0);
        measure();
        check("rev_full_b", hb[0], 300);
        check("rev_full_first_b", fb0, 1);

        // ce held high while m_k changes: only the first value counts.
        wait_cnt(1000);
        a  = 1'b1;
        ce = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m_k = 12'(100 * (k + 1));
            @(negedge clk_pid);
        end
        ce = 1'b0;
        wait_cnt(0);
        measure();
        check("cehold_ch1_a", ha[1], 100);
        check("cehold_ch1_b", hb[1], 0);
        check("cehold_ch0_b", hb[0], 300);

        // Enable drop mid-pulse, then re-enable without dead time.
        capture(0, 500);
        wait_cnt(0);
        wait_cnt(0);
        wait_cnt(100);
        check("en_pre_pwm_a0", int'(pwm_a[0]), 1);
        enable = 2'b10;
        @(negedge clk_pid);
        check("en_drop_pwm_a0", int'(pwm_a[0]), 0);
        check("en_drop_state", int'(chan_state[0]), int'(ST_IDLE));
        wait_cnt(1500);
        check("en_off_pwm_a0", int'(pwm_a[0]), 0);
        enable = 2'b11;
        wait_cnt(0);
        check("en_resume_state", int'(chan_state[0]), int'(ST_FWD));
        measure();
        check("en_resume_a0", ha[0], 500);
        check("en_resume_b0", hb[0], 0);
        check("en_resume_upd0", hu[0], 1);

        // Asynchronous reset during dead time and during a high pulse.
        capture(0, -300);
        wait_cnt(0);
        wait_cnt(5);
        check("rst_pre_dead", int'(chan_state[0]), int'(ST_DEAD));
        check("rst_pre_pwm_a1", int'(pwm_a[1]), 1);
        reset_n = 1'b0;
        #1;
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_state", int'(chan_state), 0);
        @(negedge clk_pid);
        reset_n = 1'b1;
        wait_cnt(0);
        measure();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("rst_after_ch%0d_a", c), ha[c], 0);
            check($sformatf("rst_after_ch%0d_b", c), hb[c], 0);
            check($sformatf("rst_after_ch%0d_upd", c), hu[c], 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
